// File: rtl/sel_pkg.sv
// rtl/sel_pkg.sv - shared constants and types for the select scanner
package sel_pkg;
  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [2:0] SEL_MIN = 3'd0;
  localparam logic [2:0] SEL_MAX = 3'd7;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;
endpackage

// File: rtl/presc_tick.sv
// rtl/presc_tick.sv - clock prescaler issuing one advance enable every DIV enabled clocks
module presc_tick #(
  parameter int DIV = 4,
  parameter int CW  = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic adv_en
);
  localparam logic [CW-1:0] TOP = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign adv_en = en && (cnt == TOP);

  // Count is held while disabled so an en toggle neither adds nor loses an advance.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= adv_en ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/sel_scanner.sv
// rtl/sel_scanner.sv - 3-bit select sequencer feeding a 3-to-8 decoder
module sel_scanner
  import sel_pkg::*;
#(
  parameter int DIV = 4,
  parameter int CW  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       load,
  input  logic [2:0] din,
  input  logic       step,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       tick,
  output logic       wrap
);
  logic [2:0] sel, sel_n;
  dir_t       dir, dir_n;
  logic       tick_n, wrap_n;
  logic       run, adv_en, adv;

  assign run = en && (mode != MODE_HOLD);

  presc_tick #(.DIV(DIV), .CW(CW)) u_presc (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .clr    (load),
    .adv_en (adv_en)
  );

  assign adv = (mode != MODE_HOLD) && (en ? adv_en : step);

  always_comb begin
    sel_n  = sel;
    dir_n  = dir;
    tick_n = 1'b0;
    wrap_n = 1'b0;
    if (load) begin
      sel_n = din;
      dir_n = (mode == MODE_DOWN) ? DIR_DOWN : DIR_UP;
    end else if (adv) begin
      tick_n = 1'b1;
      case (mode)
        MODE_UP: begin
          sel_n  = sel + 3'd1;
          dir_n  = DIR_UP;
          wrap_n = (sel == SEL_MAX);
        end
        MODE_DOWN: begin
          sel_n  = sel - 3'd1;
          dir_n  = DIR_DOWN;
          wrap_n = (sel == SEL_MIN);
        end
        default: begin
          // Bounce reflects off each end point instead of wrapping around.
          if (dir == DIR_UP) begin
            if (sel == SEL_MAX) begin
              sel_n  = SEL_MAX - 3'd1;
              dir_n  = DIR_DOWN;
              wrap_n = 1'b1;
            end else begin
              sel_n = sel + 3'd1;
            end
          end else begin
            if (sel == SEL_MIN) begin
              sel_n  = SEL_MIN + 3'd1;
              dir_n  = DIR_UP;
              wrap_n = 1'b1;
            end else begin
              sel_n = sel - 3'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel  <= SEL_MIN;
      dir  <= DIR_UP;
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      sel  <= sel_n;
      dir  <= dir_n;
      tick <= tick_n;
      wrap <= wrap_n;
    end
  end

  assign s0 = sel[0];
  assign s1 = sel[1];
  assign s2 = sel[2];
endmodule

// File: tb/tb_sel_scanner.sv
// tb/tb_sel_scanner.sv - self-checking bench for sel_scanner at DIV=4 and DIV=1
module tb_sel_scanner;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load, step;
  logic [1:0] mode;
  logic [2:0] din;
  logic       a_s0, a_s1, a_s2, a_tick, a_wrap;
  logic       b_s0, b_s1, b_s2, b_tick, b_wrap;

  sel_scanner #(.DIV(4), .CW(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .din(din), .step(step),
    .s0(a_s0), .s1(a_s1), .s2(a_s2), .tick(a_tick), .wrap(a_wrap)
  );

  sel_scanner #(.DIV(1), .CW(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .din(din), .step(step),
    .s0(b_s0), .s1(b_s1), .s2(b_s2), .tick(b_tick), .wrap(b_wrap)
  );

  int ntests = 0;
  int nfail  = 0;

  int msel[2];
  int mcnt[2];
  int mdir[2];
  int mtick[2];
  int mwrap[2];
  int divr[2] = '{4, 1};

  function automatic int obs_sel(input int i);
    if (i == 0) return int'({a_s2, a_s1, a_s0});
    return int'({b_s2, b_s1, b_s0});
  endfunction

  function automatic int obs_tick(input int i);
    return (i == 0) ? int'(a_tick) : int'(b_tick);
  endfunction

  function automatic int obs_wrap(input int i);
    return (i == 0) ? int'(a_wrap) : int'(b_wrap);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: dir 0 = up, 1 = down; positions move on a ring of 8 or reflect in bounce.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int adv;
      if (rst) begin
        msel[i] = 0; mcnt[i] = 0; mdir[i] = 0; mtick[i] = 0; mwrap[i] = 0;
      end else if (load) begin
        msel[i] = int'(din); mcnt[i] = 0; mdir[i] = (mode == 2'd1) ? 1 : 0;
        mtick[i] = 0; mwrap[i] = 0;
      end else begin
        adv = 0;
        if (mode != 2'd3) begin
          if (en) begin
            adv = (mcnt[i] == divr[i] - 1) ? 1 : 0;
            mcnt[i] = adv ? 0 : mcnt[i] + 1;
          end else begin
            adv = int'(step);
          end
        end
        mtick[i] = adv;
        mwrap[i] = 0;
        if (adv != 0) begin
          if (mode == 2'd0) begin
            mwrap[i] = (msel[i] == 7) ? 1 : 0;
            msel[i] = (msel[i] + 1) % 8;
            mdir[i] = 0;
          end else if (mode == 2'd1) begin
            mwrap[i] = (msel[i] == 0) ? 1 : 0;
            msel[i] = (msel[i] + 7) % 8;
            mdir[i] = 1;
          end else if (mdir[i] == 0) begin
            if (msel[i] == 7) begin msel[i] = 6; mdir[i] = 1; mwrap[i] = 1; end
            else msel[i] = msel[i] + 1;
          end else begin
            if (msel[i] == 0) begin msel[i] = 1; mdir[i] = 0; mwrap[i] = 1; end
            else msel[i] = msel[i] - 1;
          end
        end
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_sel"},  obs_sel(i),  msel[i]);
      chk({tag, "_tick"}, obs_tick(i), mtick[i]);
      chk({tag, "_wrap"}, obs_wrap(i), mwrap[i]);
    end
  endtask

  initial begin
    int ticks, wraps;
    int bseq[10] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int dseq[3]  = '{7, 6, 5};
    logic [7:0] y;

    rst = 1'b1; en = 1'b0; load = 1'b0; step = 1'b0; mode = 2'd0; din = 3'd0;
    for (int i = 0; i < 2; i++) begin
      msel[i] = 0; mcnt[i] = 0; mdir[i] = 0; mtick[i] = 0; mwrap[i] = 0;
    end
    cyc("rst");
    chk("rst_sel_a", obs_sel(0), 0);
    chk("rst_tick_a", int'(a_tick), 0);
    chk("rst_wrap_a", int'(a_wrap), 0);

    rst = 1'b0; en = 1'b1; mode = 2'd0;
    ticks = 0; wraps = 0;
    repeat (40) begin
      cyc("up");
      ticks += int'(a_tick);
      wraps += int'(a_wrap);
      if (a_wrap) chk("up_wrap_sel", obs_sel(0), 0);
    end
    chk("up_ticks", ticks, 10);
    chk("up_wraps", wraps, 1);
    chk("up_final", obs_sel(0), 2);

    load = 1'b1; din = 3'd5; mode = 2'd2;
    cyc("bload");
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc("bnc");
      chk("bnc_seq", obs_sel(1), bseq[k]);
      chk("bnc_wrap", int'(b_wrap), (k == 2 || k == 9) ? 1 : 0);
    end

    load = 1'b1; din = 3'd0; mode = 2'd0;
    cyc("ld0");
    load = 1'b0;
    cyc("cnt1");
    cyc("cnt2");
    load = 1'b1; din = 3'd6;
    cyc("ld6");
    load = 1'b0;
    chk("ld_sel", obs_sel(0), 6);
    chk("ld_tick", int'(a_tick), 0);
    repeat (3) begin
      cyc("ldwait");
      chk("ld_hold_sel", obs_sel(0), 6);
    end
    cyc("ldadv");
    chk("ld_adv_sel", obs_sel(0), 7);
    chk("ld_adv_tick", int'(a_tick), 1);

    load = 1'b1; din = 3'd0; mode = 2'd1; en = 1'b0;
    cyc("dload");
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      cyc("dstep");
      chk("step_sel", obs_sel(0), dseq[k]);
      chk("step_tick", int'(a_tick), 1);
      chk("step_wrap", int'(a_wrap), (k == 0) ? 1 : 0);
      step = 1'b0;
      cyc("didle");
      chk("step_idle_tick", int'(a_tick), 0);
    end
    repeat (20) begin
      cyc("dstable");
      chk("stable_sel", obs_sel(0), 5);
    end

    mode = 2'd3; en = 1'b1; step = 1'b1;
    repeat (10) begin
      cyc("hold");
      chk("hold_sel", obs_sel(0), 5);
      chk("hold_tick", int'(a_tick), 0);
      chk("hold_wrap", int'(a_wrap), 0);
    end
    step = 1'b0; mode = 2'd0;
    repeat (6) cyc("resume");

    rst = 1'b1; load = 1'b1; din = 3'd5;
    cyc("rstld");
    rst = 1'b0; load = 1'b0;
    chk("rstld_sel", obs_sel(0), 0);
    chk("rstld_tick", int'(a_tick), 0);
    chk("rstld_wrap", int'(a_wrap), 0);
    y = 8'h01 << {a_s2, a_s1, a_s0};
    chk("rstld_y", int'(y), 1);

    repeat (400) begin
      rst  = ($urandom % 50) == 0;
      load = ($urandom % 16) == 0;
      en   = ($urandom % 4) != 0;
      step = $urandom % 2;
      mode = 2'($urandom % 4);
      din  = 3'($urandom % 8);
      cyc("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
